// File: rtl/mem_write_buffer.sv
// In-order store FIFO between a write-through D-cache and memory; optional WB_FWD_EN forwards exact-match reads.
// Latency: store in empty buffer -> m_we one cycle after push; non-conflicting read -> m_re next cycle, c_rvalid after m_rack.
// Backpressure: c_wready drops at DEPTH entries (no pass-through on pop); reads wait while memory or a conflicting store is busy.
module mem_write_buffer #(
    parameter int DEPTH_B = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_waddr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [LEN_W-1:0]  c_wlen,
    output logic              c_wready,
    input  logic              c_re,
    input  logic [ADDR_W-1:0] c_raddr,
    input  logic [LEN_W-1:0]  c_rlen,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_rvalid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_waddr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [LEN_W-1:0]  m_wlen,
    input  logic              m_wack,
    output logic              m_re,
    output logic [ADDR_W-1:0] m_raddr,
    output logic [LEN_W-1:0]  m_rlen,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rack
);

    localparam int DEPTH = 1 << DEPTH_B;
    localparam logic [DEPTH_B:0] DEPTH_CNT = (DEPTH_B + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0]         state;
    logic [DEPTH_B-1:0] wr_ptr;
    logic [DEPTH_B-1:0] rd_ptr;
    logic [DEPTH_B:0]   count;

    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [LEN_W-1:0]  buf_len  [DEPTH];

    logic push;
    logic pop;
    logic conflict;

    assign c_wready = (count < DEPTH_CNT);
    assign push     = c_we && c_wready;
    assign pop      = (state == ST_WR) && m_wack;

`ifdef WB_FWD_EN
    logic [DEPTH_B-1:0] yng_idx;
    logic               fwd_hit;
`endif

    // Walk oldest to youngest so the last hit is the youngest conflicting entry.
    always_comb begin
        logic [DEPTH_B-1:0] idx;
        conflict = 1'b0;
        idx      = rd_ptr;
`ifdef WB_FWD_EN
        yng_idx  = rd_ptr;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + DEPTH_B'(i);
            if (((DEPTH_B + 1)'(i) < count) &&
                (buf_addr[idx][ADDR_W-1:2] == c_raddr[ADDR_W-1:2])) begin
                conflict = 1'b1;
`ifdef WB_FWD_EN
                yng_idx  = idx;
`endif
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd_hit = conflict && (buf_addr[yng_idx] == c_raddr) && (buf_len[yng_idx] == c_rlen);
`endif

    // Storage is not reset; count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= c_waddr;
            buf_data[wr_ptr] <= c_wdata;
            buf_len[wr_ptr]  <= c_wlen;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
            m_we     <= 1'b0;
            m_re     <= 1'b0;
            m_waddr  <= '0;
            m_wdata  <= '0;
            m_wlen   <= '0;
            m_raddr  <= '0;
            m_rlen   <= '0;
        end else begin
            c_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A c_re coinciding with c_rvalid is the tail of the read just completed.
                    if (c_re && !c_rvalid && !conflict) begin
                        m_raddr <= c_raddr;
                        m_rlen  <= c_rlen;
                        m_re    <= 1'b1;
                        state   <= ST_RD;
                    end
`ifdef WB_FWD_EN
                    else if (c_re && !c_rvalid && fwd_hit) begin
                        c_rdata  <= buf_data[yng_idx];
                        c_rvalid <= 1'b1;
                    end
`endif
                    else if (count != '0) begin
                        m_waddr <= buf_addr[rd_ptr];
                        m_wdata <= buf_data[rd_ptr];
                        m_wlen  <= buf_len[rd_ptr];
                        m_we    <= 1'b1;
                        state   <= ST_WR;
                    end
                end
                ST_RD: begin
                    if (m_rack) begin
                        m_re     <= 1'b0;
                        c_rdata  <= m_rdata;
                        c_rvalid <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (m_wack) begin
                        m_we  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: a toy memory acks on enable flags and every completed
// memory transaction is logged in order for comparison against hand-computed sequences.
`timescale 1ns/1ps
module tb_mem_write_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_we = 1'b0;
    logic [31:0] c_waddr = '0;
    logic [31:0] c_wdata = '0;
    logic [1:0]  c_wlen = '0;
    logic        c_wready;
    logic        c_re = 1'b0;
    logic [31:0] c_raddr = '0;
    logic [1:0]  c_rlen = '0;
    logic [31:0] c_rdata;
    logic        c_rvalid;
    logic        m_we;
    logic [31:0] m_waddr;
    logic [31:0] m_wdata;
    logic [1:0]  m_wlen;
    logic        m_wack;
    logic        m_re;
    logic [31:0] m_raddr;
    logic [1:0]  m_rlen;
    logic [31:0] m_rdata;
    logic        m_rack;

    logic        wack_en = 1'b0;
    logic        rack_en = 1'b0;
    logic [31:0] rd_val  = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int lost_cnt = 0;
    int both_cnt = 0;

    logic [31:0] ev_addr[$];
    logic [31:0] ev_data[$];
    bit          ev_rd[$];

    always #5 clk = ~clk;

    assign m_wack  = m_we & wack_en;
    assign m_rack  = m_re & rack_en;
    assign m_rdata = rd_val;

    mem_write_buffer dut (
        .clk(clk), .rst(rst),
        .c_we(c_we), .c_waddr(c_waddr), .c_wdata(c_wdata), .c_wlen(c_wlen), .c_wready(c_wready),
        .c_re(c_re), .c_raddr(c_raddr), .c_rlen(c_rlen), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
        .m_we(m_we), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wlen(m_wlen), .m_wack(m_wack),
        .m_re(m_re), .m_raddr(m_raddr), .m_rlen(m_rlen), .m_rdata(m_rdata), .m_rack(m_rack)
    );

    always @(posedge clk) begin
        if (m_we && m_wack) begin
            ev_addr.push_back(m_waddr); ev_data.push_back(m_wdata); ev_rd.push_back(1'b0);
        end
        if (m_re && m_rack) begin
            ev_addr.push_back(m_raddr); ev_data.push_back(m_rdata); ev_rd.push_back(1'b1);
        end
        // A store offered while full is silently dropped by the DUT; tally it.
        if (c_we && !c_wready && !rst) lost_cnt++;
        if (m_we && m_re) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int i, input bit rd, input logic [31:0] a, input logic [31:0] d);
        if (i >= ev_addr.size()) begin
            check({tag, "_missing"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_kind"}, 64'(ev_rd[i]), 64'(rd));
            check({tag, "_addr"}, 64'(ev_addr[i]), 64'(a));
            check({tag, "_data"}, 64'(ev_data[i]), 64'(d));
        end
    endtask

    task automatic clear_log();
        ev_addr.delete(); ev_data.delete(); ev_rd.delete();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] l);
        c_we = 1'b1; c_waddr = a; c_wdata = d; c_wlen = l;
        @(negedge clk);
        c_we = 1'b0;
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c_rvalid && n < 50);
    endtask

    initial begin
        int n;
        int lost0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_wready", 64'(c_wready), 64'd1);
        check("rst_m_we", 64'(m_we), 64'd0);
        check("rst_m_re", 64'(m_re), 64'd0);
        check("rst_rvalid", 64'(c_rvalid), 64'd0);
        check("rst_rdata", 64'(c_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset while a write is outstanding
        push(32'h10, 32'h1, 2'b10);
        push(32'h14, 32'h2, 2'b10);
        push(32'h18, 32'h3, 2'b10);
        check("midwr_m_we", 64'(m_we), 64'd1);
        check("midwr_waddr", 64'(m_waddr), 64'h10);
        check("midwr_wdata", 64'(m_wdata), 64'h1);
        rst = 1'b1;
        #1;
        check("midwr_rst_m_we", 64'(m_we), 64'd0);
        check("midwr_rst_wready", 64'(c_wready), 64'd1);
        check("midwr_rst_waddr", 64'(m_waddr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        wack_en = 1'b1;
        repeat (4) @(negedge clk);
        check("midwr_empty_m_we", 64'(m_we), 64'd0);
        check("midwr_no_writes", 64'(ev_addr.size()), 64'd0);
        wack_en = 1'b0;

        // Fill to DEPTH, overflow store, then drain in order
        clear_log();
        lost0 = lost_cnt;
        for (int i = 0; i < 4; i++) begin
            push(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
            if (i == 2) check("fill_wready_3", 64'(c_wready), 64'd1);
        end
        check("fill_wready_4", 64'(c_wready), 64'd0);
        push(32'h110, 32'hA4, 2'b10);
        check("fill_lost", 64'(lost_cnt - lost0), 64'd1);
        check("fill_head", 64'(m_waddr), 64'h100);
        wack_en = 1'b1;
        repeat (20) @(negedge clk);
        wack_en = 1'b0;
        check("fill_nwr", 64'(ev_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check_ev("fill_ev", i, 1'b0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        check("fill_wready_end", 64'(c_wready), 64'd1);
        check("fill_m_we_end", 64'(m_we), 64'd0);

        // Read priority over draining
        clear_log();
        push(32'h200, 32'h21, 2'b10);
        c_we = 1'b1; c_waddr = 32'h204; c_wdata = 32'h22; c_wlen = 2'b10;
        c_re = 1'b1; c_raddr = 32'h300; c_rlen = 2'b10;
        rack_en = 1'b1; rd_val = 32'hDEADBEEF;
        @(negedge clk);
        c_we = 1'b0;
        n = 1;
        while (!c_rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rp_rvalid", 64'(c_rvalid), 64'd1);
        check("rp_latency", 64'(n), 64'd2);
        check("rp_rdata", 64'(c_rdata), 64'hDEADBEEF);
        c_re = 1'b0;
        rack_en = 1'b0;
        check("rp_nev", 64'(ev_addr.size()), 64'd1);
        check_ev("rp_ev0", 0, 1'b1, 32'h300, 32'hDEADBEEF);
        @(negedge clk);
        check("rp_drain_start", 64'(m_we), 64'd1);
        wack_en = 1'b1;
        repeat (10) @(negedge clk);
        wack_en = 1'b0;
        check("rp_nev_end", 64'(ev_addr.size()), 64'd3);
        check_ev("rp_ev1", 1, 1'b0, 32'h200, 32'h21);
        check_ev("rp_ev2", 2, 1'b0, 32'h204, 32'h22);

`ifdef WB_FWD_EN
        // Forward youngest exact match without touching memory
        clear_log();
        push(32'h600, 32'h66, 2'b10);
        push(32'h500, 32'h11, 2'b10);
        push(32'h500, 32'h22, 2'b10);
        c_re = 1'b1; c_raddr = 32'h500; c_rlen = 2'b10;
        rd_val = 32'h00000BAD;
        wack_en = 1'b1;
        wait_rvalid(n);
        check("fwd_rvalid", 64'(c_rvalid), 64'd1);
        check("fwd_latency", 64'(n), 64'd2);
        check("fwd_rdata", 64'(c_rdata), 64'h22);
        check("fwd_m_re", 64'(m_re), 64'd0);
        c_re = 1'b0;
        repeat (10) @(negedge clk);
        wack_en = 1'b0;
        check("fwd_nev", 64'(ev_addr.size()), 64'd3);
        check_ev("fwd_ev0", 0, 1'b0, 32'h600, 32'h66);
        check_ev("fwd_ev1", 1, 1'b0, 32'h500, 32'h11);
        check_ev("fwd_ev2", 2, 1'b0, 32'h500, 32'h22);
`else
        // Conflicting read waits for both older stores
        clear_log();
        push(32'h400, 32'h41, 2'b10);
        push(32'h404, 32'h42, 2'b10);
        c_re = 1'b1; c_raddr = 32'h404; c_rlen = 2'b10;
        rd_val = 32'h5A5A5A5A;
        rack_en = 1'b1;
        wack_en = 1'b1;
        wait_rvalid(n);
        check("cd_rvalid", 64'(c_rvalid), 64'd1);
        check("cd_rdata", 64'(c_rdata), 64'h5A5A5A5A);
        c_re = 1'b0;
        rack_en = 1'b0;
        wack_en = 1'b0;
        check("cd_nev", 64'(ev_addr.size()), 64'd3);
        check_ev("cd_ev0", 0, 1'b0, 32'h400, 32'h41);
        check_ev("cd_ev1", 1, 1'b0, 32'h404, 32'h42);
        check_ev("cd_ev2", 2, 1'b1, 32'h404, 32'h5A5A5A5A);
`endif
        repeat (2) @(negedge clk);

        // Push and pop in the same cycle while full
        clear_log();
        lost0 = lost_cnt;
        for (int i = 0; i < 4; i++)
            push(32'h700 + 32'(4 * i), 32'h70 + 32'(i), 2'b10);
        check("pp_full", 64'(c_wready), 64'd0);
        c_we = 1'b1; c_waddr = 32'h710; c_wdata = 32'h99; c_wlen = 2'b10;
        wack_en = 1'b1;
        @(negedge clk);
        c_we = 1'b0;
        wack_en = 1'b0;
        check("pp_lost", 64'(lost_cnt - lost0), 64'd1);
        check("pp_count3", 64'(c_wready), 64'd1);
        push(32'h714, 32'h75, 2'b10);
        check("pp_full_again", 64'(c_wready), 64'd0);
        wack_en = 1'b1;
        repeat (20) @(negedge clk);
        wack_en = 1'b0;
        check("pp_nev", 64'(ev_addr.size()), 64'd5);
        for (int i = 0; i < 4; i++)
            check_ev("pp_ev", i, 1'b0, 32'h700 + 32'(4 * i), 32'h70 + 32'(i));
        check_ev("pp_ev4", 4, 1'b0, 32'h714, 32'h75);

        check("one_outstanding", 64'(both_cnt), 64'd0);
        check("total_lost", 64'(lost_cnt), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Sits directly downstream of the write-through data cache, between the cache's memory-side port and main memory.
- Absorbs the cache's write-through stores in a FIFO so the cache need not wait for memory.
- Drains buffered stores to memory in order.
- Passes read misses through to memory; a read that overlaps a pending store is held until that store has drained.

Parameters:
- DEPTH_B, 2, log2 of FIFO depth (DEPTH = 1<<DEPTH_B entries)
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- LEN_W, 2, access-length code width, passed through unmodified

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- c_we  in  1  store request from cache; accepted on a posedge when c_we && c_wready
- c_waddr  in  ADDR_W  store address
- c_wdata  in  DATA_W  store data
- c_wlen  in  LEN_W  store length code
- c_wready  out  1  combinational; 1 when count < DEPTH
- c_re  in  1  read request from cache; level, held until c_rvalid
- c_raddr  in  ADDR_W  read address; stable while c_re is high
- c_rlen  in  LEN_W  read length code
- c_rdata  out  DATA_W  read data; valid while c_rvalid is high
- c_rvalid  out  1  one-cycle registered pulse completing a read
- m_we  out  1  memory write request; level, held until m_wack
- m_waddr  out  ADDR_W  head-entry address
- m_wdata  out  DATA_W  head-entry data
- m_wlen  out  LEN_W  head-entry length code
- m_wack  in  1  memory write done; sampled only while m_we is high
- m_re  out  1  memory read request; level, held until m_rack
- m_raddr  out  ADDR_W  registered copy of c_raddr
- m_rlen  out  LEN_W  registered copy of c_rlen
- m_rdata  in  DATA_W  memory read data; valid with m_rack
- m_rack  in  1  memory read done; sampled only while m_re is high

Behaviour:
- Reset (async, rst=1): state=IDLE; wr_ptr=rd_ptr=0; count=0 (DEPTH_B+1 bits); c_rvalid=0; c_rdata=0; m_we=0; m_re=0; m_waddr/m_wdata/m_wlen/m_raddr/m_rlen=0. Buffered entries are discarded. An outstanding memory transaction is abandoned; memory must tolerate the request dropping.
- FIFO:
  - Circular buffer; pointers are DEPTH_B bits and wrap naturally.
  - Push on c_we && c_wready.
  - Pop on m_wack while in WR.
  - Push and pop in the same cycle: count unchanged.
  - When full, c_wready=0 even if a pop occurs that cycle; no pass-through.
  - c_we while full is ignored and the store is lost. Preventing this is the requester's duty; the bench must flag it.
- Conflict:
  - A read conflicts when any valid entry has addr[ADDR_W-1:2] == c_raddr[ADDR_W-1:2] (word granularity, length ignored).
  - Conflict is evaluated combinationally over all DEPTH entries.
- FSM states: IDLE, RD, WR.
  - IDLE:
    - c_re && !c_rvalid && !conflict: latch m_raddr/m_rlen, m_re<=1, go to RD. Reads have priority over draining.
    - Otherwise, if count>0: load m_waddr/m_wdata/m_wlen from head, m_we<=1, go to WR. This includes a conflicting read, which drains entries oldest-first until the conflict clears.
    - Otherwise stay in IDLE.
  - RD: on m_rack: m_re<=0, c_rdata<=m_rdata, c_rvalid<=1, go to IDLE.
  - WR: on m_wack: m_we<=0, pop head, go to IDLE.
- Request/pulse rules:
  - c_rvalid is high for exactly one cycle.
  - A c_re seen in the same cycle as c_rvalid is not a new request; the requester drops c_re the cycle after c_rvalid.
  - Only one memory request is outstanding at a time; m_we and m_re are never high together.
- Latency:
  - Non-conflicting read, m_rack returned the same cycle as m_re: c_re sampled at edge N, m_re high after N, c_rvalid high after N+1.
  - Store in an empty buffer: pushed at N, m_we high after N+1.
- Pushes continue in every state while not full. A push that creates a new conflict while in RD does not affect the in-flight read.

Optional Feature:
- Macro: WB_FWD_EN
- Defined:
  - In IDLE, if the youngest conflicting entry has identical address and length to the read, its data is forwarded: c_rdata<=entry data, c_rvalid<=1 next cycle, no memory read, state stays IDLE.
  - A partial or length-mismatched overlap still drains as normal.
- Undefined: every conflict drains. No forwarding logic is built.

Test Plan:
- Reset mid-WR: three stores queued, m_we high, assert rst -> count=0, m_we=0, c_wready=1, state IDLE.
- Fill: five stores to 0x100..0x110 with m_wack held 0 -> c_wready=0 after the 4th; the 5th store is not accepted; releasing m_wack drains 0x100, 0x104, 0x108, 0x10C in order.
- Read priority: buffer holds 0x200 and 0x204, read 0x300 with memory returning 0xDEADBEEF -> m_re issued before any further m_we, c_rdata=0xDEADBEEF, buffer still holds 2 entries.
- Conflict drain (WB_FWD_EN off): buffer holds 0x400 and 0x404, read 0x404 -> both stores written to memory first, then m_re with m_raddr=0x404.
- Forward (WB_FWD_EN on): store 0x500=0x11, then 0x500=0x22, read 0x500 word -> c_rvalid after 1 cycle, c_rdata=0x22, m_re stays 0.
- Simultaneous push/pop at count=4: m_wack arrives while c_we is high -> store rejected (c_wready=0), count becomes 3.
